// File: rtl/pi_ctrl_pkg.sv
// Shared types and helpers for the PI velocity controller: pipeline state
// encoding and a width-generic signed saturation test.
package pi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        MUL  = 2'd2,
        SUM  = 2'd3
    } pi_state_e;

    // Widest value the saturation helper accepts; callers sign-extend into it.
    localparam int SAT_MAX_W = 64;

    // Returns {above_max, below_min} for a signed value clipped to w bits.
    function automatic logic [1:0] sat_flags(
        input logic signed [SAT_MAX_W-1:0] v,
        input int                          w
    );
        logic signed [SAT_MAX_W-1:0] lim;
        lim = 64'sd1 <<< (w - 1);
        return {(v >= lim), (v < -lim)};
    endfunction

endpackage

// File: rtl/pi_velocity_ctrl_sat_signed.sv
// Combinational signed clip from IN_W to OUT_W bits, with flags reporting
// which rail was hit.
module sat_signed
    import pi_ctrl_pkg::*;
#(
    parameter int IN_W  = 25,
    parameter int OUT_W = 24
)(
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    hi,
    output logic                    lo
);

    logic signed [SAT_MAX_W-1:0] din_ext;
    logic [1:0]                  flags;

    assign din_ext = SAT_MAX_W'(din);
    assign flags   = sat_flags(din_ext, OUT_W);
    assign hi      = flags[1];
    assign lo      = flags[0];

    always_comb begin
        dout = din[OUT_W-1:0];
        if (hi) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (lo) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/pi_velocity_ctrl.sv
// Pipelined PI velocity controller: one sample every four cycles, saturating
// integrator with conditional-integration anti-windup.
//
// state | meaning
// IDLE  | ready, waiting for a sample
// ERR   | error and saturated integrator candidate
// MUL   | proportional and integral products
// SUM   | scale, clip, publish output, commit integrator
module pi_velocity_ctrl
    import pi_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 22,
    parameter int OUT_W  = 10
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    output logic                     ready,
    input  logic signed [DATA_W-1:0] desired_velocity,
    input  logic signed [DATA_W-1:0] actual_velocity,
    input  logic [GAIN_W-1:0]        kp,
    input  logic [GAIN_W-1:0]        ki,
    input  logic                     integ_clear,
    output logic signed [OUT_W-1:0]  output_gain,
    output logic                     out_valid,
    output logic                     sat_hi,
    output logic                     sat_lo,
    output logic                     sample_dropped,
    output logic signed [ACC_W-1:0]  integrator
);

    localparam int ERR_W = DATA_W + 1;
    localparam int P_W   = GAIN_W + DATA_W + 2;
    localparam int I_W   = GAIN_W + ACC_W + 1;
    localparam int SUM_W = ((P_W > I_W) ? P_W : I_W) + 1;

    pi_state_e state_q;
    pi_state_e state_d;

    logic signed [DATA_W-1:0] desired_q;
    logic signed [DATA_W-1:0] actual_q;
    logic [GAIN_W-1:0]        kp_q;
    logic [GAIN_W-1:0]        ki_q;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [ACC_W-1:0]  acc_cand_q;
    logic signed [P_W-1:0]    p_q;
    logic signed [I_W-1:0]    i_q;

    logic signed [ERR_W-1:0]  err_d;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc_sat;
    logic                     acc_hi;
    logic                     acc_lo;
    logic                     acc_flags_unused;

    logic signed [P_W-1:0]    kp_ext;
    logic signed [P_W-1:0]    err_ext;
    logic signed [P_W-1:0]    p_d;
    logic signed [I_W-1:0]    ki_ext;
    logic signed [I_W-1:0]    acc_ext;
    logic signed [I_W-1:0]    i_d;

    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  scaled;
    logic signed [OUT_W-1:0]  out_sat;
    logic                     out_hi;
    logic                     out_lo;
    logic                     err_pos;
    logic                     err_neg;
    logic                     windup_hold;
    logic                     accept;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (sample_valid) begin
                    state_d = ERR;
                end
            end
            ERR:     state_d = MUL;
            MUL:     state_d = SUM;
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = ready & sample_valid;

    // ---------------- ERR stage ----------------
    // One extra bit keeps desired - actual exact over the full input range.
    assign err_d   = {desired_q[DATA_W-1], desired_q} - {actual_q[DATA_W-1], actual_q};
    assign acc_sum = {integrator[ACC_W-1], integrator}
                   + {{(ACC_W+1-ERR_W){err_d[ERR_W-1]}}, err_d};

    sat_signed #(
        .IN_W  (ACC_W + 1),
        .OUT_W (ACC_W)
    ) u_acc_sat (
        .din  (acc_sum),
        .dout (acc_sat),
        .hi   (acc_hi),
        .lo   (acc_lo)
    );

    assign acc_flags_unused = acc_hi ^ acc_lo;

    // ---------------- MUL stage ----------------
    // Gains are unsigned, so they enter the signed products zero-extended.
    assign kp_ext  = {{(P_W-GAIN_W){1'b0}}, kp_q};
    assign err_ext = {{(P_W-ERR_W){err_q[ERR_W-1]}}, err_q};
    assign p_d     = kp_ext * err_ext;

    assign ki_ext  = {{(I_W-GAIN_W){1'b0}}, ki_q};
    assign acc_ext = {{(I_W-ACC_W){acc_cand_q[ACC_W-1]}}, acc_cand_q};
    assign i_d     = ki_ext * acc_ext;

    // ---------------- SUM stage ----------------
    assign sum_d  = {{(SUM_W-P_W){p_q[P_W-1]}}, p_q} + {{(SUM_W-I_W){i_q[I_W-1]}}, i_q};
    assign scaled = sum_d >>> SHIFT;

    sat_signed #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_W)
    ) u_out_sat (
        .din  (scaled),
        .dout (out_sat),
        .hi   (out_hi),
        .lo   (out_lo)
    );

    // Hold the integrator when it would only push further into a clipped rail.
    assign err_pos     = ~err_q[ERR_W-1] & (|err_q);
    assign err_neg     = err_q[ERR_W-1];
    assign windup_hold = (out_hi & err_pos) | (out_lo & err_neg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            desired_q      <= '0;
            actual_q       <= '0;
            kp_q           <= '0;
            ki_q           <= '0;
            err_q          <= '0;
            acc_cand_q     <= '0;
            p_q            <= '0;
            i_q            <= '0;
            output_gain    <= '0;
            sat_hi         <= 1'b0;
            sat_lo         <= 1'b0;
            out_valid      <= 1'b0;
            sample_dropped <= 1'b0;
            integrator     <= '0;
        end else begin
            out_valid      <= 1'b0;
            sample_dropped <= sample_valid & ~ready;

            if (accept) begin
                desired_q <= desired_velocity;
                actual_q  <= actual_velocity;
                kp_q      <= kp;
                ki_q      <= ki;
            end

            if (state_q == ERR) begin
                err_q      <= err_d;
                acc_cand_q <= acc_sat;
            end

            if (state_q == MUL) begin
                p_q <= p_d;
                i_q <= i_d;
            end

            if (state_q == SUM) begin
                output_gain <= out_sat;
                sat_hi      <= out_hi;
                sat_lo      <= out_lo;
                out_valid   <= 1'b1;
                if (!windup_hold) begin
                    integrator <= acc_cand_q;
                end
            end

            // Clear wins over a same-cycle commit; in-flight candidates are untouched.
            if (integ_clear) begin
                integrator <= '0;
            end
        end
    end

endmodule

// File: doc/pi_velocity_ctrl.md
# pi_velocity_ctrl

Parametrised, pipelined PI velocity controller for the BLDC velocity loop. It takes one velocity sample per handshake and computes a signed, saturated drive command from proportional and integral terms. The integrator saturates and uses conditional-integration anti-windup. The block sits between the velocity estimator and the PWM/commutation stage.

## Interface
- DATA_W, 16: signed width of the velocity inputs.
- GAIN_W, 16: unsigned width of kp and ki.
- ACC_W, 24: signed integrator width.
- SHIFT, 22: arithmetic right shift applied to (P+I) before output saturation.
- OUT_W, 10: signed output width.
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sample_valid  in  1  new sample present; accepted only when ready=1.
- ready  out  1  block idle and able to accept a sample.
- desired_velocity  in  DATA_W  signed setpoint.
- actual_velocity  in  DATA_W  signed measurement.
- kp, ki  in  GAIN_W each  unsigned gains, captured with the sample.
- integ_clear  in  1  zero the integrator.
- output_gain  out  OUT_W  signed saturated command.
- out_valid  out  1  one-cycle pulse when output_gain updates.
- sat_hi, sat_lo  out  1 each  output was clipped high/low; held with output_gain.
- sample_dropped  out  1  one-cycle pulse when sample_valid arrives while ready=0.
- integrator  out  ACC_W  current committed integrator value (debug/observability).

## Operation
- FSM states: IDLE, ERR, MUL, SUM. ready=1 only in IDLE.
- IDLE: on sample_valid, capture the inputs and go to ERR.
- ERR: err = desired - actual, DATA_W+1 signed, so it cannot overflow. acc_cand = sat_ACC_W(integrator + err). Go to MUL.
- MUL: p = kp * err (signed, GAIN_W+DATA_W+2 bits). i = ki * acc_cand (signed, GAIN_W+ACC_W+1 bits). Gains are zero-extended. Go to SUM.
- SUM:
  - sum = p + i at full width plus one bit, then scaled = sum >>> SHIFT (floor toward −∞).
  - output_gain = clip(scaled, −2^(OUT_W−1), 2^(OUT_W−1)−1).
  - sat_hi/sat_lo are set accordingly; out_valid=1. Go to IDLE.
- Integrator commit happens at the SUM edge: integrator ← acc_cand.
- Anti-windup exception: the commit is skipped when (sat_hi and err>0) or (sat_lo and err<0).
- integ_clear: integrator ← 0 at the next edge, in any state. It takes precedence over a same-cycle commit. An in-flight acc_cand is not altered.
- sample_valid in a non-IDLE state: the sample is ignored and sample_dropped pulses for one cycle.
- Reset (any state, mid-pipeline included) values:
  - state=IDLE.
  - integrator, output_gain, sat_hi, sat_lo, out_valid, sample_dropped all 0.
  - ready=1 in the cycle after reset is released.

## Timing
- A sample accepted at edge E produces output_gain/out_valid registered at edge E+3.
- out_valid is high for exactly one cycle.
- ready returns at E+3, so the next sample can be accepted at E+4. Maximum throughput is 1 sample per 4 cycles.
- output_gain, sat_hi and sat_lo hold their values between out_valid pulses.
- Back-to-back: with sample_valid held high continuously, samples are accepted at E, E+4, E+8…, and sample_dropped pulses at E+1..E+3.

## Structure
- Package pi_ctrl_pkg holds:
  - the state enum (IDLE, ERR, MUL, SUM);
  - a parametrised signed-saturation function used for acc_cand and the output clip.
- Natural sub-module: sat_signed (IN_W, OUT_W). It is a pure combinational clip returning the value plus hi/lo flags, instantiated twice.

## Test plan
- Reset mid-pipeline: assert reset_n=0 in the MUL state → next cycle state=IDLE, integrator=0, output_gain=0, out_valid=0, ready=1 after release.
- P-only:
  - desired=1000, actual=0, kp=0x4000, ki=0 → output_gain=3 at E+3, no saturation.
  - desired=0, actual=1, kp=1 → output_gain=−1 (floor).
- Output saturation: desired=32767, actual=−32768, kp=0xFFFF, ki=0 → output_gain=511, sat_hi=1. Swapping the inputs gives output_gain=−512, sat_lo=1.
- Anti-windup: kp=0, ki=0xFFFF, err=+65535 for 10 samples → every output 511/sat_hi, integrator stays 0. With ki=1 and err=+100 over 5 samples, integrator ends at 500.
- Integrator saturation and clear:
  - ki=0, err=+65535 repeated 200 samples → integrator clamps at 8388607.
  - integ_clear pulse → integrator=0 next edge, even when coincident with a SUM commit.
- Handshake: sample_valid held high for 12 cycles → exactly 3 out_valid pulses, spaced 4 cycles apart; sample_dropped pulses in the 9 non-accepting cycles.
